axi4_slave_wr_fifo_push: RTL and testbench
==========================================

// Module: axi4_slave_wr_fifo_push
// PURPOSE
//  AXI4 slave write-channel front end (AW/W/B) of the FIFO_AXI subsystem.
//  - Accepts single INCR/FIXED write bursts from the AXI4 master (AXI4_SLAVE agent side).
//  - Pushes every accepted W beat into the downstream FIFO write port.
//  - Returns one B response per burst. Handles one outstanding burst; no AW/W overlap.
// PARAMETERS
//  ID_W    4   AXI ID width (awid/bid)
//  ADDR_W  32  AXI address width; address is accepted but not used (FIFO has no address space)
//  DATA_W  32  AXI data width = FIFO data width; must be a power of 2, >= 8
// PORTS
//  clock         in   1         system clock; all logic on rising edge
//  reset         in   1         synchronous, active-high reset
//  awid          in   ID_W      write address ID
//  awaddr        in   ADDR_W    write address (ignored)
//  awlen         in   8         beats-1
//  awsize        in   3         log2 bytes/beat
//  awburst       in   2         00 FIXED, 01 INCR, 10 WRAP
//  awvalid       in   1         AW valid
//  awready       out  1         AW ready
//  wdata         in   DATA_W    write data
//  wstrb         in   DATA_W/8  byte strobes
//  wlast         in   1         last-beat marker from master
//  wvalid        in   1         W valid
//  wready        out  1         W ready
//  bid           out  ID_W      response ID (= captured awid)
//  bresp         out  2         00 OKAY, 10 SLVERR
//  bvalid        out  1         B valid
//  bready        in   1         B ready
//  fifo_wr_en    out  1         FIFO push strobe
//  fifo_wr_data  out  DATA_W    FIFO push data
//  fifo_full     in   1         FIFO full; no push may occur while high
//  wr_beat_count out  32        total beats pushed since reset; wraps 2^32-1 -> 0
// BEHAVIOUR
//  - Reset values: awready=0, wready=0, bvalid=0, bid=0, bresp=00, fifo_wr_en=0, wr_beat_count=0.
//    FSM goes to IDLE and awready rises on the first cycle after reset deasserts.
//  - FSM states and transitions:
//    IDLE: awready=1.
//      On awvalid&awready, capture awid, awlen, awsize, awburst; clear beat_cnt and err; go to DATA.
//    DATA: wready = ~fifo_full.
//      A beat is accepted on wvalid&wready.
//      On the accepted beat with beat_cnt==len go to RESP; otherwise beat_cnt++.
//    RESP: bvalid=1, bid=captured id, bresp = err ? SLVERR : OKAY.
//      On bready go to IDLE. bid and bresp are stable while bvalid is high.
//  - FIFO push is combinational and has zero latency:
//    fifo_wr_en = (state==DATA) & wvalid & ~fifo_full; fifo_wr_data = wdata.
//    wr_beat_count increments on each push.
//  - Burst end is decided by the beat counter, never by wlast.
//    A wlast mismatch (early, or missing on the final beat) is recorded in err; the counted length is honoured.
//  - fifo_full rising mid-burst stalls W (wready=0) with no beat lost.
//    Back-to-back beats run at 1/cycle while not full.
//  - awlen=0: single beat; DATA->RESP on the first handshake.
//  - WRAP bursts are accepted and pushed like INCR.
//  - reset asserted mid-burst: returns to IDLE immediately, drops remaining beats, issues no B.
//    The master is also reset (shared reset).
//  - Earliest turnaround: a B handshake in cycle n allows an AW handshake in cycle n+1.
// CONFIGURATION
//  Macro AXI4_SLV_WR_ERR_CHECK_EN:
//   defined: err is set on any of
//     - wlast mismatch
//     - wstrb != all-ones on any beat
//     - awsize != log2(DATA_W/8)
//     - awburst == 2'b11
//    Such bursts still push all beats and end with bresp=SLVERR.
//   undefined: err is tied 0; bresp is always OKAY; wstrb, wlast, awsize are ignored.
// STRUCTURE
//  - Shared package AXI4_SLAVE_pkg_hdl (typedefs_hdl) holds:
//     - axi_resp_t (OKAY/EXOKAY/SLVERR/DECERR)
//     - axi_burst_t (FIXED/INCR/WRAP)
//     - wr_state_t (IDLE/DATA/RESP)
//     - AXI_LEN_W=8 and AXI_RESP_W=2 constants.
//  - Single flat module; the FSM and counters are small, so no sub-module is warranted.
// TESTING
//  T1: reset 3 cycles, then INCR burst awid=3 awlen=3, data 0x11..0x44, fifo_full=0, bready=1
//      -> 4 pushes in 4 consecutive cycles, bid=3, bresp=OKAY, wr_beat_count=4.
//  T2: awlen=7, fifo_full high for 5 cycles after the 2nd beat
//      -> wready=0 and fifo_wr_en=0 during the stall; exactly 8 pushes in order; OKAY.
//  T3: awlen=0, wlast=1, bready held low 6 cycles
//      -> bvalid stays high with bid/bresp stable; awready=0 until the B handshake;
//         AW accepted 1 cycle after it.
//  T4 (EN defined): awlen=3, wlast on beat 2
//      -> still 4 pushes, bresp=SLVERR. With EN undefined, same stimulus -> OKAY.
//  T5 (EN defined): wstrb=0x3 on beat 0 of awlen=1
//      -> 2 pushes, SLVERR. Same burst with wstrb=0xF -> OKAY.
//  T6: reset asserted after beat 1 of awlen=5
//      -> next cycle: outputs at reset values, no bvalid; new burst awid=9 completes with bid=9.

Source files
------------

// File: rtl/axi4_slave_wr_fifo_push_pkg.sv
// -----------------------------------------------------------------------------
// AXI4_SLAVE_pkg_hdl -- shared typedefs for the FIFO_AXI slave write path.
//
// Contents:
//   AXI_LEN_W, AXI_RESP_W : AXI4 burst-length and response field widths
//   axi_resp_t            : OKAY / EXOKAY / SLVERR / DECERR
//   axi_burst_t           : FIXED / INCR / WRAP
//   wr_state_t            : IDLE / DATA / RESP for the write-channel FSM
//   size_for_width()      : AxSIZE that matches a full-width beat of a data bus
// -----------------------------------------------------------------------------
package AXI4_SLAVE_pkg_hdl;

   localparam int AXI_LEN_W  = 8;
   localparam int AXI_RESP_W = 2;

   typedef enum logic [AXI_RESP_W-1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DATA = 2'b01,
      ST_RESP = 2'b10
   } wr_state_t;

   // log2(bytes per beat) for a bus of data_w bits.
   function automatic logic [2:0] size_for_width(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/axi4_slave_wr_fifo_push.sv
// -----------------------------------------------------------------------------
// axi4_slave_wr_fifo_push -- AXI4 slave write channels (AW/W/B) feeding a FIFO.
//
// One burst in flight at a time: AW is taken in IDLE, every W beat is pushed
// straight into the FIFO write port (zero latency) while in DATA, and a single
// B response is returned in RESP. The burst ends on the beat counter, never on
// wlast. The AXI address is accepted but has no meaning for a FIFO.
//
// Ports:
//   clock, reset               : clock, synchronous active-high reset
//   awid/awaddr/awlen/awsize/awburst/awvalid -> awready : write address channel
//   wdata/wstrb/wlast/wvalid -> wready                   : write data channel
//   bid/bresp/bvalid <- bready                           : write response channel
//   fifo_wr_en, fifo_wr_data <- fifo_full                : FIFO push port
//   wr_beat_count              : beats pushed since reset (wraps at 2^32)
//
// Build option:
//   AXI4_SLV_WR_ERR_CHECK_EN  when defined, protocol oddities (wlast mismatch,
//   partial strobes, narrow awsize, reserved awburst) make the burst end with
//   SLVERR; all beats are still pushed. Undefined: bresp is always OKAY.
// -----------------------------------------------------------------------------
module axi4_slave_wr_fifo_push
   import AXI4_SLAVE_pkg_hdl::*;
#(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ID_W-1:0]       awid,
   input  logic [ADDR_W-1:0]     awaddr,
   input  logic [AXI_LEN_W-1:0]  awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [ID_W-1:0]       bid,
   output logic [AXI_RESP_W-1:0] bresp,
   output logic                  bvalid,
   input  logic                  bready,
   output logic                  fifo_wr_en,
   output logic [DATA_W-1:0]     fifo_wr_data,
   input  logic                  fifo_full,
   output logic [31:0]           wr_beat_count
);

   localparam int STRB_W = DATA_W / 8;

   wr_state_t            state_reg;
   logic                 awready_reg;
   logic                 bvalid_reg;
   logic [ID_W-1:0]      id_reg;
   logic [ID_W-1:0]      bid_reg;
   axi_resp_t            bresp_reg;
   logic [AXI_LEN_W-1:0] len_reg;
   logic [AXI_LEN_W-1:0] beat_cnt_reg;
   logic                 err_reg;
   logic [31:0]          beat_count_reg;

   logic aw_hs;
   logic w_hs;
   logic b_hs;
   logic last_beat;
   logic aw_err;
   logic beat_err;

   // W handshake and FIFO push are the same event: wready already folds in
   // fifo_full, so a beat can never be accepted without landing in the FIFO.
   assign wready       = (state_reg == ST_DATA) & ~fifo_full;
   assign fifo_wr_en   = (state_reg == ST_DATA) & wvalid & ~fifo_full;
   assign fifo_wr_data = wdata;
   assign w_hs         = fifo_wr_en;

   // awready_reg is only ever high in IDLE, so aw_hs implies IDLE.
   assign aw_hs     = awvalid & awready_reg;
   assign b_hs      = bvalid_reg & bready;
   assign last_beat = (beat_cnt_reg == len_reg);

`ifdef AXI4_SLV_WR_ERR_CHECK_EN
   localparam logic [2:0] FULL_SIZE = size_for_width(DATA_W);

   logic [STRB_W-1:0] lane_missing;

   generate
      for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
         assign lane_missing[gi] = ~wstrb[gi];
      end
   endgenerate

   assign aw_err   = (awsize != FULL_SIZE) | (awburst == 2'b11);
   // wlast must coincide exactly with the counted final beat.
   assign beat_err = (wlast != last_beat) | (|lane_missing);

   logic unused_ok;
   assign unused_ok = ^awaddr;
`else
   assign aw_err   = 1'b0;
   assign beat_err = 1'b0;

   logic unused_ok;
   assign unused_ok = ^{awaddr, awsize, awburst, wstrb, wlast};
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         awready_reg    <= 1'b0;
         bvalid_reg     <= 1'b0;
         id_reg         <= '0;
         bid_reg        <= '0;
         bresp_reg      <= RESP_OKAY;
         len_reg        <= '0;
         beat_cnt_reg   <= '0;
         err_reg        <= 1'b0;
         beat_count_reg <= '0;
      end else begin
         if (w_hs) begin
            beat_count_reg <= beat_count_reg + 32'd1;
         end

         case (state_reg)
            ST_IDLE: begin
               awready_reg <= 1'b1;
               if (aw_hs) begin
                  id_reg       <= awid;
                  len_reg      <= awlen;
                  beat_cnt_reg <= '0;
                  err_reg      <= aw_err;
                  awready_reg  <= 1'b0;
                  state_reg    <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (w_hs) begin
                  if (last_beat) begin
                     // bid/bresp are loaded once here and held through RESP.
                     bvalid_reg <= 1'b1;
                     bid_reg    <= id_reg;
                     bresp_reg  <= (err_reg | beat_err) ? RESP_SLVERR : RESP_OKAY;
                     state_reg  <= ST_RESP;
                  end else begin
                     beat_cnt_reg <= beat_cnt_reg + 1'b1;
                     err_reg      <= err_reg | beat_err;
                  end
               end
            end

            ST_RESP: begin
               if (b_hs) begin
                  // Raise awready right away so AW can complete the very next cycle.
                  bvalid_reg  <= 1'b0;
                  awready_reg <= 1'b1;
                  state_reg   <= ST_IDLE;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign awready       = awready_reg;
   assign bvalid        = bvalid_reg;
   assign bid           = bid_reg;
   assign bresp         = bresp_reg;
   assign wr_beat_count = beat_count_reg;

endmodule

// File: tb/tb_axi4_slave_wr_fifo_push.sv
// -----------------------------------------------------------------------------
// tb_axi4_slave_wr_fifo_push -- self-checking bench for axi4_slave_wr_fifo_push.
//
// Inputs are driven on the falling edge and outputs are sampled 1 ns later.
// The reference model tracks the protocol view of each burst: how many beats
// remain, which beat is the final one, whether the burst is malformed, and the
// total number of beats pushed since the last reset.
// -----------------------------------------------------------------------------
module tb_axi4_slave_wr_fifo_push;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic              fifo_wr_en;
   logic [DATA_W-1:0] fifo_wr_data;
   logic              fifo_full;
   logic [31:0]       wr_beat_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_total = '0;

   always #5 clock = ~clock;

   axi4_slave_wr_fifo_push #(
      .ID_W   (ID_W),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .awid          (awid),
      .awaddr        (awaddr),
      .awlen         (awlen),
      .awsize        (awsize),
      .awburst       (awburst),
      .awvalid       (awvalid),
      .awready       (awready),
      .wdata         (wdata),
      .wstrb         (wstrb),
      .wlast         (wlast),
      .wvalid        (wvalid),
      .wready        (wready),
      .bid           (bid),
      .bresp         (bresp),
      .bvalid        (bvalid),
      .bready        (bready),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_wr_data  (fifo_wr_data),
      .fifo_full     (fifo_full),
      .wr_beat_count (wr_beat_count)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      awid      = '0;
      awaddr    = '0;
      awlen     = '0;
      awsize    = 3'd2;
      awburst   = 2'b01;
      awvalid   = 1'b0;
      wdata     = '0;
      wstrb     = '1;
      wlast     = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      fifo_full = 1'b0;
   endtask

   // Called at a falling edge; holds reset for n cycles and checks reset values.
   task automatic do_reset(input int n);
      reset = 1'b1;
      idle_inputs();
      repeat (n) @(negedge clock);
      #1;
      check_val("rst_awready", awready, 1'b0);
      check_val("rst_wready", wready, 1'b0);
      check_val("rst_bvalid", bvalid, 1'b0);
      check_val("rst_bid", bid, 4'd0);
      check_val("rst_bresp", bresp, 2'b00);
      check_val("rst_push_en", fifo_wr_en, 1'b0);
      check_val("rst_beat_count", wr_beat_count, 32'd0);
      model_total = '0;
      reset = 1'b0;
      $display("reset held %0d cycles", n);
   endtask

   // One complete AW/W/B transaction.
   //   last_beat     : beat index on which wlast is driven (len = correct)
   //   bad_strb_beat : beat index driven with a partial strobe (-1 = none)
   //   stall_after/stall_len : force fifo_full for stall_len cycles once that
   //                   many beats have been pushed (-1 = none)
   task automatic run_burst(input logic [3:0] id, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int last_beat, input int bad_strb_beat,
                            input int full_pct, input int gap_pct, input int stall_after,
                            input int stall_len, input int bready_low, input bit pattern);
      bit         exp_err;
      bit         done;
      int         beats;
      int         cyc;
      int         stall_left;
      logic [1:0] exp_resp;

      // ---- address phase ----
      @(negedge clock);
      idle_inputs();
      awid    = id;
      awaddr  = $urandom;
      awlen   = 8'(len);
      awsize  = size;
      awburst = burst;
      awvalid = 1'b1;
      exp_err = (size != 3'd2) || (burst == 2'b11);
      #1;
      check_val("aw_ready_turnaround", awready, 1'b1);
      check_val("aw_no_wready", wready, 1'b0);
      check_val("aw_no_bvalid", bvalid, 1'b0);
      cyc = 0;
      while (!awready && cyc < 5) begin
         @(negedge clock);
         #1;
         cyc++;
      end
      if (!awready) check_val("aw_timeout", 1'b0, 1'b1);

      // ---- data phase ----
      @(negedge clock);
      awvalid    = 1'b0;
      beats      = 0;
      cyc        = 0;
      stall_left = stall_len;
      while (beats <= len && cyc < 400) begin
         wvalid    = ($urandom_range(99) >= gap_pct);
         fifo_full = ($urandom_range(99) < full_pct);
         if (stall_after >= 0 && beats == stall_after && stall_left > 0) begin
            fifo_full = 1'b1;
            stall_left--;
         end
         wdata = pattern ? DATA_W'((beats + 1) * 32'h11) : DATA_W'($urandom);
         wlast = (beats == last_beat);
         wstrb = (beats == bad_strb_beat) ? STRB_W'(4'h3) : '1;
         #1;
         check_val("wready", wready, !fifo_full);
         check_val("push_en", fifo_wr_en, wvalid && !fifo_full);
         check_val("beat_count", wr_beat_count, model_total);
         check_val("data_no_bvalid", bvalid, 1'b0);
         if (wvalid && !fifo_full) begin
            check_val("push_data", fifo_wr_data, wdata);
            if ((wlast != (beats == len)) || (wstrb != '1)) exp_err = 1'b1;
            beats++;
            model_total++;
         end
         @(negedge clock);
         cyc++;
      end
      if (beats <= len) check_val("w_timeout", 1'b0, 1'b1);

`ifdef AXI4_SLV_WR_ERR_CHECK_EN
      exp_resp = exp_err ? 2'b10 : 2'b00;
`else
      exp_resp = 2'b00;
`endif

      // ---- response phase: a stray wvalid must not be pushed here ----
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 50) begin
         bready    = (cyc >= bready_low);
         wvalid    = 1'b1;
         wdata     = DATA_W'($urandom);
         wlast     = 1'b0;
         fifo_full = 1'b0;
         #1;
         check_val("bvalid", bvalid, 1'b1);
         check_val("bid", bid, id);
         check_val("bresp", bresp, exp_resp);
         check_val("resp_awready", awready, 1'b0);
         check_val("resp_no_push", fifo_wr_en, 1'b0);
         check_val("resp_beat_count", wr_beat_count, model_total);
         if (bready) done = 1'b1;
         else begin
            @(negedge clock);
            cyc++;
         end
      end
      $display("burst id=%0d len=%0d size=%0d burst=%0d err_cond=%0d resp=%0d total=%0d",
               id, len, size, burst, exp_err, exp_resp, model_total);
   endtask

   // Start a burst, push `keep` beats, then reset in the middle of it.
   task automatic abort_burst(input logic [3:0] id, input int len, input int keep);
      @(negedge clock);
      idle_inputs();
      awid    = id;
      awlen   = 8'(len);
      awvalid = 1'b1;
      #1;
      check_val("abort_awready", awready, 1'b1);
      @(negedge clock);
      awvalid = 1'b0;
      wvalid  = 1'b1;
      for (int i = 0; i < keep; i++) begin
         wdata = DATA_W'($urandom);
         #1;
         check_val("abort_push_en", fifo_wr_en, 1'b1);
         check_val("abort_push_data", fifo_wr_data, wdata);
         model_total++;
         @(negedge clock);
      end
      $display("burst id=%0d len=%0d aborted by reset after %0d beats", id, len, keep);
      do_reset(1);
   endtask

   initial begin
      idle_inputs();

      // T1: basic INCR burst with known data pattern
      do_reset(3);
      #1;
      check_val("awready_low_after_reset", awready, 1'b0);
      run_burst(4'd3, 3, 3'd2, 2'b01, 3, -1, 0, 0, -1, 0, 0, 1'b1);

      // T2: FIFO full for 5 cycles after the second beat
      run_burst(4'd5, 7, 3'd2, 2'b01, 7, -1, 0, 0, 2, 5, 0, 1'b1);

      // T3: single beat, bready held low for 6 cycles, then immediate turnaround
      run_burst(4'd7, 0, 3'd2, 2'b00, 0, -1, 0, 0, -1, 0, 6, 1'b0);

      // T4: wlast early on beat 2 of a 4-beat burst
      run_burst(4'd2, 3, 3'd2, 2'b01, 2, -1, 0, 0, -1, 0, 0, 1'b0);

      // T5: partial strobe on beat 0, then the same burst with full strobes
      run_burst(4'd4, 1, 3'd2, 2'b01, 1, 0, 0, 0, -1, 0, 0, 1'b0);
      run_burst(4'd4, 1, 3'd2, 2'b01, 1, -1, 0, 0, -1, 0, 0, 1'b0);

      // WRAP accepted like INCR; narrow size and reserved burst type
      run_burst(4'd6, 3, 3'd2, 2'b10, 3, -1, 0, 0, -1, 0, 1, 1'b0);
      run_burst(4'd8, 2, 3'd1, 2'b01, 2, -1, 0, 0, -1, 0, 0, 1'b0);
      run_burst(4'd10, 2, 3'd2, 2'b11, 2, -1, 0, 0, -1, 0, 0, 1'b0);

      // T6: reset after beat 1 of a 6-beat burst, then a fresh burst
      abort_burst(4'd1, 5, 2);
      run_burst(4'd9, 2, 3'd2, 2'b01, 2, -1, 0, 0, -1, 0, 0, 1'b0);

      // Randomized bursts
      for (int n = 0; n < 40; n++) begin
         int         len;
         int         lb;
         int         bs;
         logic [2:0] sz;
         logic [1:0] bt;
         len = $urandom_range(15);
         lb  = ($urandom_range(5) == 0) ? int'($urandom_range(16)) : len;
         bs  = ($urandom_range(7) == 0) ? int'($urandom_range(15)) : -1;
         sz  = ($urandom_range(9) == 0) ? 3'd1 : 3'd2;
         bt  = ($urandom_range(9) == 0) ? 2'b11 : 2'($urandom_range(2));
         run_burst(4'($urandom), len, sz, bt, lb, bs, $urandom_range(40), $urandom_range(30),
                   -1, 0, $urandom_range(3), 1'b0);
      end

      // Back in IDLE with nothing pending
      @(negedge clock);
      idle_inputs();
      #1;
      check_val("final_bvalid", bvalid, 1'b0);
      check_val("final_awready", awready, 1'b1);
      check_val("final_beat_count", wr_beat_count, model_total);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
